regfile_sb: RTL and testbench

Parametrised register file with write-to-read bypass, a per-entry busy scoreboard and a live count of outstanding reservations. It succeeds the fixed 32x32, two-read-port register file in the processor datapath. It serves the multi-issue FFT control core: decode reserves a destination, writeback fills it, and dependent reads see either forwarded data or a busy flag.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_sb_entry.sv | 32 +++
 rtl/regfile_sb.sv | 101 ++++++++++
 tb/tb_regfile_sb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry and
// the address-validity test that honours the hardwired-zero entry.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_NUM_READ   = 2;
    localparam int DEPTH              = 2 ** DEFAULT_ADDR_WIDTH;

    function automatic logic addrValid(input int unsigned addr, input logic zeroReg);
        return !(zeroReg && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_sb_entry.sv
// One register-file entry: a data register plus its busy flag, both cleared
// asynchronously. A set-busy request wins over clear-busy in the same cycle.
module regfile_entry #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  writeEnable,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  setBusy,
    input  logic                  clearBusy,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  busy
);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            data <= '0;
            busy <= 1'b0;
        end else begin
            if (writeEnable) begin
                data <= writeData;
            end
            if (setBusy) begin
                busy <= 1'b1;
            end else if (clearBusy) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with same-cycle write bypass, per-entry busy
// scoreboard and a registered count of outstanding reservations.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_READ   = DEFAULT_NUM_READ,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                           clock,
    input  logic                           ctrl_reset_n,
    input  logic                           ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]          data_writeReg,
    input  logic                           ctrl_reserveEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_reserveReg,
    input  logic                           ctrl_flush,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    output logic [NUM_READ-1:0]            busy_readReg,
    output logic [ADDR_WIDTH:0]            busy_count
);

    localparam int ENTRIES = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    logic                  writeValid;
    logic                  reserveValid;
    logic                  bypassValid;
    logic [DATA_WIDTH-1:0] entryData [ENTRIES];
    logic                  entryBusy [ENTRIES];
    logic                  countInc;
    logic                  countDec;
    logic [ADDR_WIDTH:0]   countNext;

    assign writeValid   = ctrl_writeEnable && addrValid(32'(ctrl_writeReg), ZERO_REG);
    assign reserveValid = ctrl_reserveEnable && addrValid(32'(ctrl_reserveReg), ZERO_REG);
    // Forwarding is suppressed under reset so every read output is zero then.
    assign bypassValid  = writeValid && ctrl_reset_n;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        if (ZERO_REG && (i == 0)) begin : g_zero
            assign entryData[i] = '0;
            assign entryBusy[i] = 1'b0;
        end else begin : g_reg
            logic hitWrite;
            logic hitReserve;
            assign hitWrite   = writeValid && (ctrl_writeReg == ADDR_WIDTH'(i));
            assign hitReserve = reserveValid && !ctrl_flush && (ctrl_reserveReg == ADDR_WIDTH'(i));
            regfile_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
                .clock      (clock),
                .resetN     (ctrl_reset_n),
                .writeEnable(hitWrite),
                .writeData  (data_writeReg),
                .setBusy    (hitReserve),
                .clearBusy  (hitWrite || ctrl_flush),
                .data       (entryData[i]),
                .busy       (entryBusy[i])
            );
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] readAddr;
        logic                  readZero;
        logic                  readBypass;
        assign readAddr   = ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign readZero   = ZERO_REG && (readAddr == '0);
        assign readBypass = bypassValid && (ctrl_writeReg == readAddr);
        assign data_readReg[k*DATA_WIDTH +: DATA_WIDTH] =
            readZero   ? '0 :
            readBypass ? data_writeReg : entryData[readAddr];
        assign busy_readReg[k] = !readZero && !readBypass && entryBusy[readAddr];
    end

    // A write only retires a reservation if the same edge does not re-reserve it.
    assign countInc = reserveValid && !entryBusy[ctrl_reserveReg];
    assign countDec = writeValid && entryBusy[ctrl_writeReg]
                      && !(reserveValid && (ctrl_reserveReg == ctrl_writeReg));

    always_comb begin
        countNext = busy_count;
        if (ctrl_flush) begin
            countNext = '0;
        end else if (countInc && !countDec) begin
            countNext = busy_count + COUNT_ONE;
        end else if (countDec && !countInc) begin
            countNext = busy_count - COUNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            busy_count <= '0;
        end else begin
            busy_count <= countNext;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized checks of regfile_sb against an array-based model
// of register contents and reservations.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic            clock = 1'b0;
    logic            ctrl_reset_n;
    logic            ctrl_writeEnable;
    logic [AW-1:0]   ctrl_writeReg;
    logic [DW-1:0]   data_writeReg;
    logic            ctrl_reserveEnable;
    logic [AW-1:0]   ctrl_reserveReg;
    logic            ctrl_flush;
    logic [NR*AW-1:0] ctrl_readReg;
    logic [NR*DW-1:0] data_readReg;
    logic [NR-1:0]   busy_readReg;
    logic [AW:0]     busy_count;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] modelMem  [DEPTH];
    bit            modelBusy [DEPTH];

    always #5 clock = ~clock;

    regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1'b1)) dut (
        .clock             (clock),
        .ctrl_reset_n      (ctrl_reset_n),
        .ctrl_writeEnable  (ctrl_writeEnable),
        .ctrl_writeReg     (ctrl_writeReg),
        .data_writeReg     (data_writeReg),
        .ctrl_reserveEnable(ctrl_reserveEnable),
        .ctrl_reserveReg   (ctrl_reserveReg),
        .ctrl_flush        (ctrl_flush),
        .ctrl_readReg      (ctrl_readReg),
        .data_readReg      (data_readReg),
        .busy_readReg      (busy_readReg),
        .busy_count        (busy_count)
    );

    function automatic int modelCount();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(modelBusy[i]);
        return c;
    endfunction

    function automatic logic [DW-1:0] expData(input logic [AW-1:0] a);
        if (!ctrl_reset_n || a == 0) return '0;
        if (ctrl_writeEnable && ctrl_writeReg == a) return data_writeReg;
        return modelMem[a];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        if (!ctrl_reset_n || a == 0) return 1'b0;
        if (ctrl_writeEnable && ctrl_writeReg == a) return 1'b0;
        return modelBusy[a];
    endfunction

    task automatic resetModel();
        for (int i = 0; i < DEPTH; i++) begin
            modelMem[i]  = '0;
            modelBusy[i] = 1'b0;
        end
    endtask

    task automatic updateModel();
        if (ctrl_flush)
            for (int i = 0; i < DEPTH; i++) modelBusy[i] = 1'b0;
        if (ctrl_writeEnable && ctrl_writeReg != 0) begin
            modelMem[ctrl_writeReg]  = data_writeReg;
            modelBusy[ctrl_writeReg] = 1'b0;
        end
        if (ctrl_reserveEnable && ctrl_reserveReg != 0 && !ctrl_flush)
            modelBusy[ctrl_reserveReg] = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] a;
            a = ctrl_readReg[k*AW +: AW];
            checkOutput($sformatf("%s.data%0d", tag, k), data_readReg[k*DW +: DW], expData(a));
            checkOutput($sformatf("%s.busy%0d", tag, k), {31'b0, busy_readReg[k]}, {31'b0, expBusy(a)});
        end
        checkOutput($sformatf("%s.count", tag), 32'(busy_count), 32'(modelCount()));
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic re, input logic [AW-1:0] ra, input logic fl,
                                 input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        ctrl_writeEnable   = we;
        ctrl_writeReg      = wa;
        data_writeReg      = wd;
        ctrl_reserveEnable = re;
        ctrl_reserveReg    = ra;
        ctrl_flush         = fl;
        ctrl_readReg       = {r1, r0};
    endtask

    task automatic runCycle(input string tag);
        @(negedge clock);
        checkAll(tag);
        updateModel();
        @(posedge clock);
        #1;
    endtask

    initial begin
        ctrl_reset_n = 1'b0;
        resetModel();
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd5);
        #3;
        checkAll("reset");
        checkOutput("reset.data3", data_readReg[DW-1:0], 32'h0);
        @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;

        applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd3, 5'd5);
        runCycle("wr3");
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd5);
        #1;
        checkOutput("rd3", data_readReg[DW-1:0], 32'hDEADBEEF);

        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd3);
        runCycle("rsv5");
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd3);
        #1;
        checkOutput("rsv5.busy", {31'b0, busy_readReg[0]}, 32'd1);
        checkOutput("rsv5.count", 32'(busy_count), 32'd1);

        applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd5, 5'd3);
        #1;
        checkOutput("byp5.data", data_readReg[DW-1:0], 32'h12345678);
        checkOutput("byp5.busy", {31'b0, busy_readReg[0]}, 32'd0);
        runCycle("wr5");
        checkOutput("wr5.count", 32'(busy_count), 32'd0);

        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd5);
        runCycle("rsv7");
        applyStimulus(1'b1, 5'd7, 32'hA5, 1'b1, 5'd7, 1'b0, 5'd7, 5'd5);
        runCycle("wrrsv7");
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd5);
        #1;
        checkOutput("wrrsv7.data", data_readReg[DW-1:0], 32'hA5);
        checkOutput("wrrsv7.busy", {31'b0, busy_readReg[0]}, 32'd1);
        checkOutput("wrrsv7.count", 32'(busy_count), 32'd1);

        applyStimulus(1'b1, 5'd7, 32'hA5, 1'b0, 5'd0, 1'b0, 5'd7, 5'd1);
        runCycle("free7");
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd1, 1'b0, 5'd1, 5'd2);
        runCycle("rsv1");
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd2, 1'b0, 5'd1, 5'd2);
        runCycle("rsv2");
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd2);
        runCycle("rsv4");
        checkOutput("rsv124.count", 32'(busy_count), 32'd3);
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd6, 1'b1, 5'd6, 5'd1);
        runCycle("flush");
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd6, 5'd4);
        #1;
        checkOutput("flush.count", 32'(busy_count), 32'd0);
        checkOutput("flush.busy6", {31'b0, busy_readReg[0]}, 32'd0);
        checkAll("postflush");

        applyStimulus(1'b1, 5'd2, 32'h55, 1'b1, 5'd3, 1'b0, 5'd2, 5'd3);
        runCycle("setup");
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        #1;
        checkOutput("zero.data", data_readReg[DW-1:0], 32'h0);
        checkOutput("zero.busy", {31'b0, busy_readReg[0]}, 32'd0);
        runCycle("zero");
        checkOutput("zero.count", 32'(busy_count), 32'd1);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom), 5'($urandom), $urandom, 1'($urandom),
                          5'($urandom), ($urandom_range(0, 15) == 0),
                          5'($urandom), 5'($urandom));
            runCycle($sformatf("rand%0d", n));
        end

        applyStimulus(1'b1, 5'd3, 32'hCAFEF00D, 1'b1, 5'd9, 1'b0, 5'd3, 5'd9);
        runCycle("prerst");
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd9);
        #2;
        ctrl_reset_n = 1'b0;
        resetModel();
        #1;
        checkOutput("arst.data3", data_readReg[DW-1:0], 32'h0);
        checkOutput("arst.busy9", {31'b0, busy_readReg[1]}, 32'd0);
        checkOutput("arst.count", 32'(busy_count), 32'd0);
        checkAll("arst");
        @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;
        runCycle("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
